// File: rtl/rf_pkg.sv
// Shared constants, write-select bundle and the write-port arbitration
// function used by both the register write path and the read bypass.
package rf_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int ZERO_REG       = 0;
    localparam int MAX_PORTS      = 8;
    localparam int MAX_AW         = 8;
    localparam int PORT_W         = 3;

    typedef struct packed {
        logic              hit;
        logic [PORT_W-1:0] port;
    } wr_sel_t;

    // Ports are scanned low to high so the highest-numbered match wins.
    function automatic wr_sel_t wr_winner(
        input logic [MAX_PORTS-1:0]        en,
        input logic [MAX_PORTS*MAX_AW-1:0] idx,
        input logic [MAX_AW-1:0]           target
    );
        wr_sel_t sel;
        sel = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (en[i] && idx[i*MAX_AW +: MAX_AW] == target) begin
                sel.hit  = 1'b1;
                sel.port = PORT_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Busy-bit scoreboard: writes clear, allocation sets, and a same-edge
// allocation beats a write because it names the newer producer.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_WRITE  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_en,
    input  logic [ADDR_WIDTH-1:0]         alloc_index,
    input  logic [NUM_WRITE-1:0]          wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_index,
    output logic [2**ADDR_WIDTH-1:0]      busy_vec
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w]) begin
                busy_next[wr_index[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_next[alloc_index] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port integer register file with optional write-to-read bypass
// and a busy scoreboard for RAW hazard detection at issue.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rs_index,
    output logic [NUM_READ*XLEN-1:0]        rs_data,
    output logic [NUM_READ-1:0]             rs_busy,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_index,
    input  logic [NUM_WRITE*XLEN-1:0]       wr_data,
    input  logic                            alloc_en,
    input  logic [ADDR_WIDTH-1:0]           alloc_index,
    output logic [2**ADDR_WIDTH-1:0]        busy_vec
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [XLEN-1:0]               regs [DEPTH];
    logic [MAX_PORTS-1:0]          en_pad;
    logic [MAX_PORTS*MAX_AW-1:0]   idx_pad;
    wr_sel_t                       wsel [DEPTH];

    // Widen the write ports to the fixed shape the arbiter expects.
    always_comb begin
        en_pad  = '0;
        idx_pad = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            en_pad[w] = wr_en[w];
            idx_pad[w*MAX_AW +: MAX_AW] =
                MAX_AW'(wr_index[w*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_wsel
        assign wsel[r] = wr_winner(en_pad, idx_pad, MAX_AW'(r));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (r != ZERO_REG && wsel[r].hit) begin
                    regs[r] <= wr_data[int'(wsel[r].port)*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] idx;
        wr_sel_t               sel;
        logic                  zero;
        logic                  byp;

        assign idx  = rs_index[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero = (idx == ADDR_WIDTH'(ZERO_REG));
        assign sel  = wr_winner(en_pad, idx_pad, MAX_AW'(idx));
        assign byp  = (BYPASS != 0) && sel.hit && !zero;

        assign rs_data[p*XLEN +: XLEN] =
            zero ? '0 :
            byp  ? wr_data[int'(sel.port)*XLEN +: XLEN] :
                   regs[idx];

        assign rs_busy[p] = !zero && busy_vec[idx] && !byp;
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WRITE  (NUM_WRITE)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_index (alloc_index),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised and directed bench for both bypass variants of the register
// file, checked against an array-based reference model.
module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rs_index;
    logic [63:0] rs_data_b, rs_data_n;
    logic [1:0]  rs_busy_b, rs_busy_n;
    logic [1:0]  wr_en;
    logic [9:0]  wr_index;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_index;
    logic [31:0] busy_vec_b, busy_vec_n;

    logic [31:0] mreg [32];
    logic [31:0] mbusy;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multiport_register_file #(.BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .rs_index(rs_index),
        .rs_data(rs_data_b), .rs_busy(rs_busy_b), .wr_en(wr_en),
        .wr_index(wr_index), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_index(alloc_index), .busy_vec(busy_vec_b)
    );

    multiport_register_file #(.BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .rs_index(rs_index),
        .rs_data(rs_data_n), .rs_busy(rs_busy_n), .wr_en(wr_en),
        .wr_index(wr_index), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_index(alloc_index), .busy_vec(busy_vec_n)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] idx);
        bit h = 0;
        for (int w = 0; w < 2; w++)
            if (wr_en[w] && wr_index[w*5 +: 5] == idx) h = 1;
        return h;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] idx,
                                             input bit byp);
        logic [31:0] v;
        v = mreg[idx];
        if (idx == 0) return 32'h0;
        if (byp)
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_index[w*5 +: 5] == idx)
                    v = wr_data[w*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx, input bit byp);
        if (idx == 0) return 1'b0;
        return mbusy[idx] && !(byp && hit(idx));
    endfunction

    task automatic go(input logic rst, input logic [4:0] r0, r1,
                      input logic e0, input logic [4:0] i0,
                      input logic [31:0] d0,
                      input logic e1, input logic [4:0] i1,
                      input logic [31:0] d1,
                      input logic ae, input logic [4:0] ai);
        logic [4:0] idx;
        reset = rst;
        rs_index = {r1, r0};
        wr_en = {e1, e0};
        wr_index = {i1, i0};
        wr_data = {d1, d0};
        alloc_en = ae;
        alloc_index = ai;
        #2;
        for (int p = 0; p < 2; p++) begin
            idx = rs_index[p*5 +: 5];
            check($sformatf("rd%0d_data_byp x%0d", p, idx),
                  rs_data_b[p*32 +: 32], exp_data(idx, 1));
            check($sformatf("rd%0d_data_nobyp x%0d", p, idx),
                  rs_data_n[p*32 +: 32], exp_data(idx, 0));
            check($sformatf("rd%0d_busy_byp x%0d", p, idx),
                  rs_busy_b[p], exp_busy(idx, 1));
            check($sformatf("rd%0d_busy_nobyp x%0d", p, idx),
                  rs_busy_n[p], exp_busy(idx, 0));
        end
        check("busy_vec_byp", busy_vec_b, mbusy);
        check("busy_vec_nobyp", busy_vec_n, mbusy);
        @(posedge clk);
        if (!rst) begin
            for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
            mbusy = 32'h0;
        end else begin
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_index[w*5 +: 5] != 0)
                    mreg[wr_index[w*5 +: 5]] = wr_data[w*32 +: 32];
            for (int w = 0; w < 2; w++)
                if (wr_en[w]) mbusy[wr_index[w*5 +: 5]] = 1'b0;
            if (ae && ai != 0) mbusy[ai] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        rs_index = '0;
        wr_en = '0;
        wr_index = '0;
        wr_data = '0;
        alloc_en = 1'b0;
        alloc_index = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
        mbusy = 32'h0;

        // Fill every register and mark it busy, then reset with traffic.
        for (int i = 1; i < 32; i++)
            go(1, 5'(i), 0, 1, 5'(i), 32'hFFFF_FFFF, 0, 0, 0, 1, 5'(i));
        go(0, 31, 1, 1, 3, 32'h5, 1, 4, 32'h6, 1, 8);
        for (int i = 0; i < 32; i += 2)
            go(1, 5'(i), 5'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0);

        go(1, 5, 6, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0);
        go(1, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0);

        go(1, 7, 7, 1, 7, 32'hAAAA, 1, 7, 32'hBBBB, 0, 0);
        go(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        go(1, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 1, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        go(1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        go(1, 9, 0, 1, 9, 32'h55, 0, 0, 0, 0, 0);
        go(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        go(1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 10);
        go(1, 10, 10, 0, 0, 0, 1, 10, 32'h77, 1, 10);
        go(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Narrow index range forces frequent collisions.
        for (int n = 0; n < 400; n++)
            go(1'($urandom_range(0, 49) != 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom), 5'($urandom_range(0, 7)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
Parametrised integer register file with NUM_READ combinational read ports and NUM_WRITE synchronous write ports. Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard used by issue logic to detect RAW hazards. Sits between decode/issue and writeback, and replaces the single-write, two-read register file in multi-issue configurations. Register 0 is hard-wired to zero.

Parameters:
XLEN, 32, data width of each register
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (>=1)
NUM_WRITE, 2, number of write ports (>=1)
BYPASS, 1, 1 = a read returns write data presented in the same cycle; 0 = a read returns registered contents only

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-low reset
rs_index  in  NUM_READ*ADDR_WIDTH  read indices; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]
rs_data  out  NUM_READ*XLEN  read data; port p occupies [p*XLEN +: XLEN]
rs_busy  out  NUM_READ  scoreboard busy flag for each read index
wr_en  in  NUM_WRITE  write enable per write port
wr_index  in  NUM_WRITE*ADDR_WIDTH  write indices
wr_data  in  NUM_WRITE*XLEN  write data
alloc_en  in  1  issue allocates a destination register (marks it busy)
alloc_index  in  ADDR_WIDTH  destination register being allocated
busy_vec  out  2**ADDR_WIDTH  raw scoreboard state, bit i = register i busy

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. While reset=0 at a rising edge, ALL 2**ADDR_WIDTH registers clear to 0 and all busy bits clear to 0. Writes and allocs in that cycle are ignored. Afterwards every rs_data reads 0, and rs_busy and busy_vec read 0.
- Reset asserted mid-operation discards any in-flight write or alloc in that cycle; there is no partial update.
- Writes: when wr_en[w]=1 at an edge, registers[wr_index[w]] takes wr_data[w]. The value is visible through the array one cycle later.
- Write conflict: if several enabled ports target the same index, the highest-numbered port wins. Other ports still write their own indices.
- Index 0: writes to index 0 are dropped. A read of index 0 always returns 0 and never reports busy, regardless of BYPASS.
- Reads: combinational, zero latency.
  - BYPASS=1: if any enabled write port targets the read index in the current cycle (and the index is not 0), rs_data returns the winning port's wr_data. Otherwise it returns the array value.
  - BYPASS=0: rs_data always returns the array value.
- Scoreboard set: alloc_en=1 with alloc_index≠0 sets busy[alloc_index] at the next edge. An alloc to index 0 is ignored.
- Scoreboard clear: an enabled write clears busy[wr_index] at the edge.
- Simultaneous alloc and write to the same index: the busy bit ends SET, because the new producer takes precedence over the old one.
- Alloc of an already-busy register keeps the bit set. This is legal: WAW is handled by issue logic.
- rs_busy[p] = busy[rs_index[p]] AND NOT (BYPASS=1 and an enabled write hits rs_index[p] this cycle). rs_busy is 0 for index 0. It does not reflect an alloc made in the same cycle.
- busy_vec is the registered busy state with no bypass term. Bit 0 is always 0.
- All index arithmetic is unsigned ADDR_WIDTH bits, so no out-of-range index is possible.

Decomposition:
- Package rf_pkg holds:
  - default constants for XLEN and ADDR_WIDTH, and ZERO_REG = 0
  - a function that returns the winning write port, and a hit flag, for a given index (shared by the write path and the bypass mux)
- Sub-module rf_scoreboard: holds the busy-bit array and its set/clear priority. Parameters are ADDR_WIDTH and NUM_WRITE; ports are clk, reset, alloc_en, alloc_index, wr_en, wr_index and busy_vec. The top-level module instantiates it and forms rs_busy from its output.

Test Plan:
- Reset clears all: write 0xFFFFFFFF to every index 1..31 on port 0, pulse reset=0 for one cycle, then read all 32 indices -> every read is 0, busy_vec=0. This covers index 31 explicitly.
- Dual write, then read: port0 writes x5=0x11, port1 writes x6=0x22 in one cycle; next cycle rs_index={5,6} -> rs_data={0x11,0x22}.
- Write conflict: port0 x7=0xAAAA and port1 x7=0xBBBB in the same cycle -> next cycle x7 reads 0xBBBB. With BYPASS=1, the same-cycle read of x7 also returns 0xBBBB.
- Zero register: port1 writes x0=0x1234 and alloc_en with alloc_index=0 -> x0 reads 0 in the same and following cycles, busy_vec[0]=0.
- Scoreboard: alloc x9 -> next cycle rs_busy=1 for x9. Write x9=0x55 -> with BYPASS=1, rs_busy=0 and rs_data=0x55 in that cycle; the next cycle busy_vec[9]=0.
- Simultaneous alloc and write on x10 while x10 is busy -> busy_vec[10]=1 afterwards, and x10 holds the written value. Repeat with BYPASS=0: the same-cycle read returns the old value and rs_busy=1.
